display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 113 +++++++++++
 rtl/display_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Purpose: shared types and constants for the stepped-clock / 7-segment debug display block.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents: debounce FSM state type, active-low hex-to-segment table, blank/off codes.
package display_pkg;

    // Debounce FSM states for the step pushbutton.
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        PULSE        = 3'd2,
        HELD         = 3'd3,
        WAIT_RELEASE = 3'd4
    } deb_state_t;

    // Hex digit to cathode pattern, active-low, bit 7 = dp (off), bits 6:0 = {g,f,e,d,c,b,a}.
    // Entry 0 sits in the least significant byte, so HEX_SEG[n] is the code for digit n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;  // all cathodes off, dp off
    localparam logic [3:0] AN_OFF    = 4'hF;   // all anodes off
    localparam logic [7:0] SEG_DP_ON = 8'h7F;  // AND mask that lights the dp

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: debounce the (already synchronized) step button and emit one active-low cpu_clk pulse per accepted press.
// Latency: pulse starts on the edge that sees the DEBOUNCE_CYCLES-th consecutive high sample; lasts PULSE_LEN cycles.
// Backpressure: none; holding the button stalls the FSM in HELD, no further pulses until a debounced release.
//
// Ports: core_clk / arst_n (async active-low), btn (synchronized, high = pressed),
//        cpu_clk (registered, idles high, resets high asynchronously).
module btn_debounce
    import display_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PULSE_LEN       = 4
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic btn,
    output logic cpu_clk
);

    localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [CW-1:0]  DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_LEN - 1);

    deb_state_t     state;
    logic [CW-1:0]  deb_cnt;
    logic [PCW-1:0] pulse_cnt;

    // The synchronizer feeding btn comes out of reset holding 0 for two cycles,
    // which would look like a release. warm_up marks when btn reflects the real
    // pin; armed is only set once a genuine low has been seen after that, so a
    // button held through reset cannot be taken as a fresh press.
    logic [1:0] warm_up;
    logic       armed;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            pulse_cnt <= '0;
            cpu_clk   <= 1'b1;
            warm_up   <= '0;
            armed     <= 1'b0;
        end else begin
            warm_up <= {warm_up[0], 1'b1};

            case (state)
                IDLE: begin
                    deb_cnt <= '0;
                    if (!armed) begin
                        if (warm_up[1] && !btn) begin
                            armed <= 1'b1;
                        end
                    end else if (btn) begin
                        // This cycle is the first high sample of the run.
                        state   <= WAIT_PRESS;
                        deb_cnt <= CW'(1);
                    end
                end

                WAIT_PRESS: begin
                    if (!btn) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt >= DEB_LAST) begin
                        state     <= PULSE;
                        cpu_clk   <= 1'b0;
                        pulse_cnt <= '0;
                        deb_cnt   <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end

                PULSE: begin
                    // Runs to completion even if the button is released mid-pulse.
                    if (pulse_cnt >= PULSE_LAST) begin
                        cpu_clk <= 1'b1;
                        state   <= HELD;
                    end else begin
                        pulse_cnt <= pulse_cnt + PCW'(1);
                    end
                end

                HELD: begin
                    if (!btn) begin
                        state   <= WAIT_RELEASE;
                        deb_cnt <= CW'(1);
                    end
                end

                WAIT_RELEASE: begin
                    if (btn) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                    end else if (deb_cnt >= DEB_LAST) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                    cpu_clk <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Purpose: single-step CPU clock from a debounced button, plus a 4-digit multiplexed hex display of a selected debug word.
// Latency: an/seg registered, 1 cycle after the digit index changes; displayed word changes only at frame start.
// Backpressure: none; free-running scan, button presses beyond one per hold are ignored.
//
// Ports: CLK, Reset (async active-low), btn_step (raw, high = pressed), sel[1:0] (selects sig1..sig4),
//        sig1..sig4[15:0] debug words, cpu_clk (idles high), an[3:0] (active-low, an[3] = MS nibble),
//        seg[7:0] (active-low, seg[7] = dp).
// Build option: DISPLAY_LEADING_BLANK_EN blanks leading zero digits 3..1 (digit 0 always shown).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PULSE_LEN       = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        btn_step,
    input  logic [1:0]  sel,
    input  logic [15:0] sig1,
    input  logic [15:0] sig2,
    input  logic [15:0] sig3,
    input  logic [15:0] sig4,
    output logic        cpu_clk,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(REFRESH_DIV - 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic       btn_s1, btn_s2;
    logic [1:0] sel_s1, sel_s2;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sel_s1 <= 2'b00;
            sel_s2 <= 2'b00;
        end else begin
            btn_s1 <= btn_step;
            btn_s2 <= btn_s1;
            sel_s1 <= sel;
            sel_s2 <= sel_s1;
        end
    end

    // ------------------------------------------------------------------
    // Step button -> cpu_clk
    // ------------------------------------------------------------------
    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .PULSE_LEN       (PULSE_LEN)
    ) u_btn_debounce (
        .core_clk (CLK),
        .arst_n   (Reset),
        .btn      (btn_s2),
        .cpu_clk  (cpu_clk)
    );

    // ------------------------------------------------------------------
    // Scan timing, digit index and frame snapshot
    // ------------------------------------------------------------------
    logic [SW-1:0] scan_cnt;
    logic          scan_wrap;
    logic [1:0]    digit_idx;
    logic [15:0]   frame;
    logic [15:0]   sel_word;

    assign scan_wrap = (scan_cnt == SCAN_LAST);

    always_comb begin
        sel_word = sig1;
        case (sel_s2)
            2'd0:    sel_word = sig1;
            2'd1:    sel_word = sig2;
            2'd2:    sel_word = sig3;
            default: sel_word = sig4;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            frame     <= 16'h0000;
        end else begin
            if (scan_wrap) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
                // Snapshot only at the 3 -> 0 step so every frame shows one
                // coherent word even if sel or the sig bus moves mid-frame.
                if (digit_idx == 2'd3) begin
                    frame <= sel_word;
                end
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit decode
    // ------------------------------------------------------------------
    logic [3:0] cur_nib;
    logic [7:0] seg_nxt;
    logic [3:0] an_nxt;

`ifdef DISPLAY_LEADING_BLANK_EN
    // lead_zero[i]: nibble i and every nibble above it are zero.
    logic [3:0] lead_zero;

    always_comb begin
        lead_zero    = 4'b0000;
        lead_zero[3] = (frame[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (frame[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (frame[7:4] == 4'h0);
        lead_zero[0] = 1'b0;  // units digit is never blanked
    end
`endif

    always_comb begin
        cur_nib = frame[{digit_idx, 2'b00} +: 4];
        an_nxt  = ~(4'b0001 << digit_idx);
        seg_nxt = hex_to_seg(cur_nib);
        // dp on digit 2 separates the high byte from the low byte.
        if (digit_idx == 2'd2) begin
            seg_nxt = seg_nxt & SEG_DP_ON;
        end
`ifdef DISPLAY_LEADING_BLANK_EN
        if (lead_zero[digit_idx]) begin
            seg_nxt = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns/1ps
module tb_display_scan_ctrl;

    localparam int REFRESH_DIV     = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int PULSE_LEN       = 2;

    logic        CLK      = 1'b0;
    logic        Reset    = 1'b0;
    logic        btn_step = 1'b0;
    logic [1:0]  sel      = 2'd0;
    logic [15:0] sig1     = 16'h0000;
    logic [15:0] sig2     = 16'h0000;
    logic [15:0] sig3     = 16'h0000;
    logic [15:0] sig4     = 16'h0000;
    logic        cpu_clk;
    logic [3:0]  an;
    logic [7:0]  seg;

    always #5 CLK = ~CLK;

    display_scan_ctrl #(
        .REFRESH_DIV     (REFRESH_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .PULSE_LEN       (PULSE_LEN)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .btn_step (btn_step),
        .sel      (sel),
        .sig1     (sig1),
        .sig2     (sig2),
        .sig3     (sig3),
        .sig4     (sig4),
        .cpu_clk  (cpu_clk),
        .an       (an),
        .seg      (seg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model for the display ----------------
    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] f, input int d);
        logic [7:0] s;
        s = seg_of(f[4*d +: 4]);
        if (d == 2) s[7] = 1'b0;
`ifdef DISPLAY_LEADING_BLANK_EN
        if (d > 0 && (f >> (4*d)) == 16'h0000) s = 8'hFF;
`endif
        return s;
    endfunction

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [7:0] seg;
    } disp_exp_t;

    disp_exp_t disp_q[$];

    task automatic push_frame(input string tag, input logic [15:0] f);
        disp_exp_t e;
        logic [3:0] a;
        for (int d = 0; d < 4; d++) begin
            a = 4'b0001 << d;
            e.tag = $sformatf("%s_d%0d", tag, d);
            e.an  = ~a;
            e.seg = exp_seg(f, d);
            disp_q.push_back(e);
        end
    endtask

    // Compare the digit currently on the display with the next expectation.
    task automatic check_cur_digit();
        disp_exp_t e;
        if (disp_q.size() == 0) begin
            check_eq("disp_queue_empty", 32'd0, 32'd1);
        end else begin
            e = disp_q.pop_front();
            check_eq({e.tag, "_an"}, {28'd0, an}, {28'd0, e.an});
            check_eq({e.tag, "_seg"}, {24'd0, seg}, {24'd0, e.seg});
        end
    endtask

    task automatic check_next_digit();
        repeat (REFRESH_DIV) @(negedge CLK);
        check_cur_digit();
    endtask

    // Align to the first negedge on which digit 0 has just been lit.
    task automatic wait_digit0(input string tag);
        logic [3:0] prev;
        int found;
        found = 0;
        prev  = an;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge CLK);
            if (an == 4'b1110 && prev != 4'b1110) found = 1;
            prev = an;
        end
        check_eq({tag, "_frame_sync"}, found, 1);
    endtask

    // ---------------- cpu_clk pulse monitor / scoreboard ----------------
    int low_run = 0;
    int pulse_q[$];
    int exp_pulse_q[$];

    always @(negedge CLK) begin
        if (cpu_clk == 1'b0) begin
            low_run++;
        end else if (low_run > 0) begin
            pulse_q.push_back(low_run);
            low_run = 0;
        end
    end

    task automatic check_pulses(input string tag);
        check_eq({tag, "_pulse_count"}, pulse_q.size(), exp_pulse_q.size());
        while (pulse_q.size() > 0 && exp_pulse_q.size() > 0)
            check_eq({tag, "_pulse_width"}, pulse_q.pop_front(), exp_pulse_q.pop_front());
        pulse_q.delete();
        exp_pulse_q.delete();
    endtask

    task automatic drive_btn(input logic v, input int cycles);
        btn_step = v;
        repeat (cycles) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;

        // Reset state
        repeat (3) @(negedge CLK);
        check_eq("rst_cpu_clk", {31'd0, cpu_clk}, 32'd1);
        check_eq("rst_an", {28'd0, an}, 32'hF);
        check_eq("rst_seg", {24'd0, seg}, 32'hFF);

        Reset = 1'b1;
        @(negedge CLK);
        // Frame register is 0 and digit index 0 straight out of reset.
        check_eq("post_rst_an", {28'd0, an}, 32'hE);
        check_eq("post_rst_seg", {24'd0, seg}, 32'hC0);

        // Clean press held 30 cycles: one 2-cycle pulse, nothing on release.
        repeat (5) @(negedge CLK);
        exp_pulse_q.push_back(PULSE_LEN);
        drive_btn(1'b1, 30);
        drive_btn(1'b0, 30);
        check_pulses("clean_press");

        // Bounce shorter than the debounce window: no pulse.
        drive_btn(1'b1, 5);
        drive_btn(1'b0, 1);
        drive_btn(1'b1, 5);
        drive_btn(1'b0, 20);
        check_pulses("bounce");

        // Then a stable 10-cycle press: one pulse.
        exp_pulse_q.push_back(PULSE_LEN);
        drive_btn(1'b1, 10);
        drive_btn(1'b0, 30);
        check_pulses("stable_press");

        // sel = 2 shows sig3 = 12AB: B, A, 2 with dp, 1.
        sig1 = 16'h5A5A;
        sig3 = 16'h12AB;
        sel  = 2'd2;
        push_frame("sig3", 16'h12AB);
        wait_digit0("sig3_a");
        wait_digit0("sig3_b");
        check_cur_digit();
        for (int k = 0; k < 3; k++) check_next_digit();

        // sel 0 -> 1 during digit 1: rest of the frame stays sig1, sig2 from next digit 0.
        sig1 = 16'h1234;
        sig2 = 16'hABCD;
        sel  = 2'd0;
        push_frame("sel_old", 16'h1234);
        push_frame("sel_new", 16'hABCD);
        wait_digit0("sel_a");
        wait_digit0("sel_b");
        check_cur_digit();
        check_next_digit();
        sel = 2'd1;
        for (int k = 0; k < 6; k++) check_next_digit();

`ifdef DISPLAY_LEADING_BLANK_EN
        sel  = 2'd0;
        sig1 = 16'h0005;
        push_frame("blank5", 16'h0005);
        wait_digit0("blank5_a");
        wait_digit0("blank5_b");
        check_cur_digit();
        for (int k = 0; k < 3; k++) check_next_digit();
        sig1 = 16'h0000;
        push_frame("blank0", 16'h0000);
        wait_digit0("blank0_a");
        wait_digit0("blank0_b");
        check_cur_digit();
        for (int k = 0; k < 3; k++) check_next_digit();
`endif

        // Reset while cpu_clk is low: outputs return to idle asynchronously.
        btn_step = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge CLK);
            if (cpu_clk == 1'b0) found = 1;
        end
        check_eq("mid_pulse_reached", found, 1);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("async_rst_cpu_clk", {31'd0, cpu_clk}, 32'd1);
        check_eq("async_rst_an", {28'd0, an}, 32'hF);
        check_eq("async_rst_seg", {24'd0, seg}, 32'hFF);
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        // Discard the truncated pulse cut short by reset.
        pulse_q.delete();
        exp_pulse_q.delete();

        // Button held through reset release: no pulse.
        drive_btn(1'b1, 40);
        drive_btn(1'b0, 30);
        check_pulses("held_through_reset");

        // A genuine new press afterwards is accepted.
        exp_pulse_q.push_back(PULSE_LEN);
        drive_btn(1'b1, 20);
        drive_btn(1'b0, 30);
        check_pulses("rearm_press");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
